// File: rtl/cordic_atan2_if.sv
// cordic_atan2_if: sample in / result out handshake bundle.
// master produces samples and consumes results; slave is the core.
interface cordic_atan2_if #(
  parameter int IN_W = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] x;
  logic signed [IN_W-1:0] y;
  logic                   out_valid;
  logic                   out_ready;
  logic [11:0]            degree;
  logic [IN_W-1:0]        mag;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, degree, mag
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, degree, mag
  );
endinterface

// File: rtl/cordic_atan2.sv
// cordic_atan2: pipelined vectoring CORDIC, atan2 in 0.1 deg + magnitude.
// One global advance enable stalls every stage under backpressure.
module cordic_atan2 #(
  parameter int IN_W = 10,
  parameter int ITER = 12,
  parameter int FRAC = 8
) (
  input logic          clk,
  input logic          rst_n,
  cordic_atan2_if.slave bus
);
  // x/y keep IN_W+2 integer bits plus GB guard fraction bits so that
  // small vectors still converge instead of stalling on y = -1 LSB.
  localparam int GB = 16;
  localparam int W  = IN_W + 2 + GB;
  localparam int AW = 13 + FRAC;
  localparam int KB = 24;
  localparam int PW = W + KB;

  // 0.607253 (CORDIC 1/gain) with KB fraction bits
  localparam logic [KB-1:0] KC = 24'd10188014;
  localparam logic signed [AW-1:0] A180 = AW'(1800 << FRAC);
  localparam logic signed [AW-1:0] AHALF = AW'(1 << (FRAC - 1));
  localparam logic [PW-1:0] MHALF =
    {{(PW-1){1'b0}}, 1'b1} << (GB + KB - 1);
  localparam logic [PW-1:0] MMAX =
    {{(PW-IN_W){1'b0}}, {IN_W{1'b1}}};

  // atan(2^-i) in 0.1 deg, scaled by 2^16, rounded
  localparam longint T16 [16] = '{
    29491200, 17409672, 9198793, 4669451,
    2343786,  1173036,  586661,  293348,
    146676,   73339,    36669,   18335,
    9167,     4584,     2292,    1146
  };

  function automatic logic signed [AW-1:0] tab(input int i);
    longint v;
    v = T16[i];
    if (FRAC < 16)
      v = (v + (64'sd1 <<< (15 - FRAC))) >>> (16 - FRAC);
    return AW'(v);
  endfunction

  logic                   ce;
  logic signed [W-1:0]    xs [ITER+1];
  logic signed [W-1:0]    ys [ITER+1];
  logic signed [AW-1:0]   as [ITER+1];
  logic                   vs [ITER+1];
  logic                   zs [ITER+1];
  logic signed [W-1:0]    nx [ITER];
  logic signed [W-1:0]    ny [ITER];
  logic signed [AW-1:0]   na [ITER];
  logic signed [W-1:0]    xe;
  logic signed [W-1:0]    ye;
  logic signed [AW-1:0]   ang;
  logic [PW-1:0]          prod;
  logic [PW-1:0]          mr;
  logic [11:0]            deg_c;
  logic [IN_W-1:0]        mag_c;
  logic                   ov;
  logic [11:0]            deg_q;
  logic [IN_W-1:0]        mag_q;

  assign ce            = !ov || bus.out_ready;
  assign bus.in_ready  = ce;
  assign bus.out_valid = ov;
  assign bus.degree    = deg_q;
  assign bus.mag       = mag_q;

  // widen inputs into the guarded datapath
  always_comb begin
    xe = {{2{bus.x[IN_W-1]}}, bus.x, {GB{1'b0}}};
    ye = {{2{bus.y[IN_W-1]}}, bus.y, {GB{1'b0}}};
  end

  // micro-rotation arithmetic, driving y toward zero
  always_comb begin
    for (int i = 0; i < ITER; i++) begin
      if (!ys[i][W-1]) begin
        nx[i] = xs[i] + (ys[i] >>> i);
        ny[i] = ys[i] - (xs[i] >>> i);
        na[i] = as[i] + tab(i);
      end else begin
        nx[i] = xs[i] - (ys[i] >>> i);
        ny[i] = ys[i] + (xs[i] >>> i);
        na[i] = as[i] - tab(i);
      end
    end
  end

  // round/wrap the angle and apply the gain correction to x
  always_comb begin
    ang = (as[ITER] + AHALF) >>> FRAC;
    if (ang < 0)
      ang = ang + AW'(3600);
    if (ang == AW'(3600))
      ang = '0;
    deg_c = ang[11:0];
    prod  = {{KB{1'b0}}, xs[ITER]} * {{W{1'b0}}, KC};
    mr    = (prod + MHALF) >> (GB + KB);
    if (mr > MMAX)
      mag_c = '1;
    else
      mag_c = mr[IN_W-1:0];
    // (0,0) would otherwise sum every table entry
    if (zs[ITER]) begin
      deg_c = '0;
      mag_c = '0;
    end
  end

  // pipeline registers; ce advances all stages together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= ITER; k++) begin
        vs[k] <= 1'b0;
        zs[k] <= 1'b0;
        xs[k] <= '0;
        ys[k] <= '0;
        as[k] <= '0;
      end
      ov    <= 1'b0;
      deg_q <= '0;
      mag_q <= '0;
    end else if (ce) begin
      vs[0] <= bus.in_valid;
      zs[0] <= (bus.x == '0) && (bus.y == '0);
      xs[0] <= bus.x[IN_W-1] ? -xe : xe;
      ys[0] <= bus.x[IN_W-1] ? -ye : ye;
      as[0] <= bus.x[IN_W-1] ? A180 : '0;
      for (int i = 0; i < ITER; i++) begin
        vs[i+1] <= vs[i];
        zs[i+1] <= zs[i];
        xs[i+1] <= nx[i];
        ys[i+1] <= ny[i];
        as[i+1] <= na[i];
      end
      ov    <= vs[ITER];
      deg_q <= deg_c;
      mag_q <= mag_c;
    end
  end
endmodule
